// File: rtl/seq_checker_16bit.sv
// Sequence checker for the free-running counter stream: locks after LOCK_CNT good increments,
// then flags every word that is not previous+1 (mod 2^WIDTH). Optional: SEQ_CHK_ZERO_RESYNC_EN.
module seq_checker_16bit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             resync_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_TGT = 8'(UNLOCK_CNT);

  logic [1:0]       state, state_n;
  logic [7:0]       good_run, good_n;
  logic [7:0]       miss_run, miss_n;
  logic [WIDTH-1:0] exp_n;
  logic [ERR_W-1:0] err_n;
  logic [WIDTH-1:0] data_inc;
  logic [7:0]       good_inc, miss_inc;
  logic             match;
  logic             err_hit;
  logic             zero_resync;

  assign data_inc = data_in + WIDTH'(1);
  assign good_inc = good_run + 8'd1;
  assign miss_inc = miss_run + 8'd1;
  assign match    = (data_in == expected);

  // A mismatching zero while locked is read as the producer restarting, not as an error.
`ifdef SEQ_CHK_ZERO_RESYNC_EN
  assign zero_resync = en && (state == S_LOCKED) && !match && (data_in == '0);
`else
  assign zero_resync = 1'b0;
`endif

  always_comb begin
    state_n = state;
    good_n  = good_run;
    miss_n  = miss_run;
    exp_n   = expected;
    err_hit = 1'b0;
    if (en) begin
      // Every qualified word re-seeds expected so the checker follows the received stream.
      exp_n = data_inc;
      case (state)
        S_UNLOCKED: begin
          good_n  = '0;
          state_n = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          if (match) begin
            good_n = good_inc;
            if (good_inc == LOCK_TGT) begin
              state_n = S_LOCKED;
              miss_n  = '0;
            end
          end else begin
            good_n = '0;
          end
        end
        S_LOCKED: begin
          if (match) begin
            miss_n = '0;
          end else if (!zero_resync) begin
            err_hit = 1'b1;
            miss_n  = miss_inc;
            if (miss_inc == UNLOCK_TGT) begin
              state_n = S_UNLOCKED;
              good_n  = '0;
            end
          end
        end
        default: begin
          state_n = S_UNLOCKED;
          good_n  = '0;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the pulse itself is unaffected.
  always_comb begin
    err_n = err_count;
    if (clr_err)
      err_n = '0;
    else if (err_hit && (err_count != '1))
      err_n = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_UNLOCKED;
      good_run     <= '0;
      miss_run     <= '0;
      expected     <= '0;
      err_count    <= '0;
      err_pulse    <= 1'b0;
      resync_pulse <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_n;
      good_run     <= good_n;
      miss_run     <= miss_n;
      expected     <= exp_n;
      err_count    <= err_n;
      err_pulse    <= err_hit;
      resync_pulse <= zero_resync;
      locked       <= (state_n == S_LOCKED);
    end
  end

endmodule

// File: tb/tb_seq_checker_16bit.sv
// Self-checking bench for seq_checker_16bit: directed vector table, hand sequences, and
// randomized traffic against a behavioural model (default build and ERR_W=2 instance).
module tb_seq_checker_16bit;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] data_in = '0;

  logic        locked, err_pulse, resync_pulse;
  logic [7:0]  err_count;
  logic [15:0] expected;
  logic        s_locked, s_err_pulse, s_resync_pulse;
  logic [1:0]  s_err_count;
  logic [15:0] s_expected;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_checker_16bit #(.WIDTH(16), .LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .resync_pulse(resync_pulse),
    .err_count(err_count), .expected(expected));

  seq_checker_16bit #(.WIDTH(16), .LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_err(clr_err),
    .locked(s_locked), .err_pulse(s_err_pulse), .resync_pulse(s_resync_pulse),
    .err_count(s_err_count), .expected(s_expected));

`ifdef SEQ_CHK_ZERO_RESYNC_EN
  localparam bit ZERO_RESYNC = 1'b1;
`else
  localparam bit ZERO_RESYNC = 1'b0;
`endif

  // Behavioural model: counts and flags derived directly from the stream rules.
  bit m_captured, m_locked, m_pulse, m_resync;
  int m_good, m_miss, m_errs, m_exp;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit c, input int d);
    bit err;
    err = 1'b0;
    m_resync = 1'b0;
    if (r) begin
      m_captured = 0; m_locked = 0; m_good = 0; m_miss = 0; m_errs = 0; m_exp = 0;
      m_pulse = 0;
      return;
    end
    if (e) begin
      if (!m_captured) begin
        m_captured = 1; m_good = 0;
      end else if (!m_locked) begin
        if (d == m_exp) begin
          m_good++;
          if (m_good == LOCK_N) begin m_locked = 1; m_miss = 0; end
        end else m_good = 0;
      end else if (d == m_exp) begin
        m_miss = 0;
      end else if (ZERO_RESYNC && d == 0) begin
        m_resync = 1'b1;
      end else begin
        err = 1'b1;
        m_miss++;
        if (m_miss == UNLOCK_N) begin m_locked = 0; m_captured = 0; m_good = 0; end
      end
      m_exp = (d + 1) % 65536;
    end
    m_pulse = err;
    if (c) m_errs = 0;
    else if (err) m_errs++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input logic [15:0] d);
    @(negedge clk);
    rst = r; en = e; clr_err = c; data_in = d;
    @(posedge clk);
    model_step(r, e, c, int'(d));
    #1;
  endtask

  task automatic check_all(input string tag, input bit lk, input bit pl, input bit rs,
                           input int cnt, input int ex);
    check({tag, ".locked"}, int'(locked), int'(lk));
    check({tag, ".err_pulse"}, int'(err_pulse), int'(pl));
    check({tag, ".resync_pulse"}, int'(resync_pulse), int'(rs));
    check({tag, ".err_count"}, int'(err_count), sat(cnt, 255));
    check({tag, ".expected"}, int'(expected), ex);
    check({tag, ".sat_err_count"}, int'(s_err_count), sat(cnt, 3));
    check({tag, ".sat_locked"}, int'(s_locked), int'(lk));
    check({tag, ".sat_expected"}, int'(s_expected), ex);
  endtask

  typedef struct {
    bit          r, e, c;
    logic [15:0] d;
    bit          lk, pl;
    int          cnt;
    int          ex;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit c, int d, bit lk, bit pl, int cnt, int ex);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.d = 16'(d); v.lk = lk; v.pl = pl; v.cnt = cnt; v.ex = ex;
    return v;
  endfunction

  initial begin
    // reset, lock on 100..104
    tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100,    0, 0, 0, 101));
    tbl.push_back(mk(0, 1, 0, 101,    0, 0, 0, 102));
    tbl.push_back(mk(0, 1, 0, 102,    0, 0, 0, 103));
    tbl.push_back(mk(0, 1, 0, 103,    0, 0, 0, 104));
    tbl.push_back(mk(0, 1, 0, 104,    1, 0, 0, 105));
    // jump to 0xFFFE (one error), wrap with en=0 gap
    tbl.push_back(mk(0, 1, 0, 'hFFFE, 1, 1, 1, 'hFFFF));
    tbl.push_back(mk(0, 1, 0, 'hFFFF, 1, 0, 1, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h1234, 1, 0, 1, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h0007, 1, 0, 1, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'hFFFF, 1, 0, 1, 'h0000));
    tbl.push_back(mk(0, 1, 0, 'h0000, 1, 0, 1, 'h0001));
    tbl.push_back(mk(0, 1, 0, 'h0001, 1, 0, 1, 'h0002));
    // single error with expected=50: 60 then 61
    tbl.push_back(mk(0, 1, 0, 49,     1, 1, 2, 50));
    tbl.push_back(mk(0, 1, 0, 60,     1, 1, 3, 61));
    tbl.push_back(mk(0, 1, 0, 61,     1, 0, 3, 62));
    // repeated word is a mismatch
    tbl.push_back(mk(0, 1, 0, 61,     1, 1, 4, 62));
    tbl.push_back(mk(0, 1, 0, 62,     1, 0, 4, 63));
    // clear collides with mismatch
    tbl.push_back(mk(0, 1, 1, 1000,   1, 1, 0, 1001));
    tbl.push_back(mk(0, 1, 0, 1001,   1, 0, 0, 1002));
    // four consecutive mismatches drop lock; ERR_W=2 instance saturates
    tbl.push_back(mk(0, 1, 0, 5000,   1, 1, 1, 5001));
    tbl.push_back(mk(0, 1, 0, 6000,   1, 1, 2, 6001));
    tbl.push_back(mk(0, 1, 0, 7000,   1, 1, 3, 7001));
    tbl.push_back(mk(0, 1, 0, 8000,   0, 1, 4, 8001));
    tbl.push_back(mk(0, 1, 0, 9000,   0, 0, 4, 9001));
    // reacquire and fifth error
    tbl.push_back(mk(0, 1, 0, 9001,   0, 0, 4, 9002));
    tbl.push_back(mk(0, 1, 0, 9002,   0, 0, 4, 9003));
    tbl.push_back(mk(0, 1, 0, 9003,   0, 0, 4, 9004));
    tbl.push_back(mk(0, 1, 0, 9004,   1, 0, 4, 9005));
    tbl.push_back(mk(0, 1, 0, 3,      1, 1, 5, 4));
    // en=0 with clr still clears
    tbl.push_back(mk(0, 0, 1, 77,     1, 0, 0, 4));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].d);
      check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].pl, 1'b0, tbl[i].cnt, tbl[i].ex);
    end

    // zero resync: lock with expected=500, then 0, 1
    step(1, 0, 0, 0);
    for (int v = 495; v < 500; v++) step(0, 1, 0, 16'(v));
    check_all("zr.lock", 1, 0, 0, 0, 500);
    step(0, 1, 0, 0);
    if (ZERO_RESYNC) check_all("zr.zero", 1, 0, 1, 0, 1);
    else             check_all("zr.zero", 1, 1, 0, 1, 1);
    step(0, 1, 0, 1);
    check_all("zr.one", 1, 0, 0, ZERO_RESYNC ? 0 : 1, 2);

    // reset while locked, with a pending error count
    step(0, 1, 0, 40);
    step(1, 1, 0, 41);
    check_all("rst.mid", 0, 0, 0, 0, 0);

    // randomized traffic vs model
    model_step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      bit r, e, c;
      int d, pick;
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 9) < 8);
      pick = $urandom_range(0, 99);
      if (pick < 82)      d = m_exp;
      else if (pick < 88) d = (m_exp + 65535) % 65536;
      else if (pick < 93) d = 0;
      else if (pick < 96) d = 'hFFFF;
      else                d = $urandom_range(0, 65535);
      step(r, e, c, 16'(d));
      check("rnd.locked", int'(locked), int'(m_locked));
      check("rnd.err_pulse", int'(err_pulse), int'(m_pulse));
      check("rnd.resync_pulse", int'(resync_pulse), int'(m_resync));
      check("rnd.err_count", int'(err_count), sat(m_errs, 255));
      check("rnd.expected", int'(expected), m_exp);
      check("rnd.sat_err_count", int'(s_err_count), sat(m_errs, 3));
      check("rnd.sat_pulse", int'(s_err_pulse), int'(m_pulse));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_checker_16bit.md
# seq_checker_16bit

Sequence checker that receives the free-running count produced by the team's 16-bit enabled counter user design, one sampled word per qualified cycle. It locks onto the sequence, then flags every word that is not the previous word plus one, modulo 2^WIDTH. It sits at the consumer end of the counter pin bundle on the 8x8 demo fabric and reports lock status, error pulses and a saturating error count.

## Interface
- WIDTH, 16, width of the checked count word
- LOCK_CNT, 4, consecutive correct increments required to assert lock (1..255)
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that drop lock (1..255)
- ERR_W, 8, width of the error counter

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  sample qualifier; data_in is evaluated only on cycles with en=1
- data_in  in  WIDTH  received count word
- clr_err  in  1  synchronous clear of err_count
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle pulse per mismatch counted in LOCKED
- resync_pulse  out  1  one-cycle pulse per zero-resync (macro build only, else tied 0)
- err_count  out  ERR_W  saturating mismatch count
- expected  out  WIDTH  next value the checker expects

## Operation
- States: UNLOCKED, ACQUIRE, LOCKED. Internal run counters good_run and miss_run, 8 bits each.
- en=0: no state, counter or output-register change; pulses deassert.
- UNLOCKED, en=1: expected <= data_in+1, good_run <= 0, go to ACQUIRE.
- ACQUIRE, en=1, data_in==expected: good_run+1, expected <= data_in+1. Reaching LOCK_CNT -> LOCKED, miss_run <= 0.
- ACQUIRE, en=1, mismatch: expected <= data_in+1, good_run <= 0, stay. No error is counted outside LOCKED.
- LOCKED, en=1, match: miss_run <= 0, expected <= data_in+1.
- LOCKED, en=1, mismatch: err_pulse, err_count+1 saturating at 2^ERR_W-1, miss_run+1, and expected <= data_in+1 so the checker follows the received stream. Reaching UNLOCK_CNT -> UNLOCKED with good_run <= 0.
- A repeated word (data_in==expected-1) is a mismatch. The producer holding its count must be masked by en=0 upstream.
- Wrap: expected after 0xFFFF is 0x0000. The comparison is WIDTH-bit modulo, and 0xFFFF -> 0x0000 is a match.
- clr_err=1 forces err_count to 0 on the next edge. It takes precedence over a simultaneous error increment, but err_pulse still fires.
- rst takes precedence over everything.

## Timing
- All outputs are registered. err_pulse, resync_pulse, locked and expected update on the edge that samples the offending or completing word, so they are visible one cycle after the en=1 input cycle.
- Minimum lock latency from reset is LOCK_CNT+1 qualified samples: one capture plus LOCK_CNT matches.
- Unlock occurs on the UNLOCK_CNT-th consecutive mismatch. err_pulse fires on that same edge.
- Reset values: state UNLOCKED, locked 0, err_pulse 0, resync_pulse 0, err_count 0, expected 0, good_run 0, miss_run 0.
- rst asserted mid-lock: the next edge returns every register to its reset value, and err_count is lost.

## Configuration
- SEQ_CHK_ZERO_RESYNC_EN defined: in LOCKED, a mismatching data_in==0 is treated as a producer reset.
  - No err_pulse, no err_count or miss_run change.
  - resync_pulse=1, expected <= 1, state stays LOCKED.
- SEQ_CHK_ZERO_RESYNC_EN undefined: zero gets no special handling. A mismatching 0 is an ordinary mismatch, and resync_pulse is constant 0.

## Test plan
- Lock: after rst, drive en=1 with data 100,101,102,103,104 -> locked=1 after the 104 edge, expected=105, err_count=0.
- Wrap and hold: in LOCKED, drive 0xFFFE, 0xFFFF, then en=0 for 3 cycles, then 0x0000, 0x0001 -> no err_pulse, locked stays 1, expected=0x0002.
- Single error: in LOCKED with expected=50, drive 60 then 61 -> one err_pulse, err_count=1, locked stays 1, expected=62.
- Unlock and saturation:
  - In LOCKED, drive 4 consecutive non-sequential words -> err_count+4, locked=0 after the 4th.
  - With ERR_W=2, 5 errors -> err_count=3.
- Zero resync: in LOCKED with expected=500, drive 0 then 1. Macro defined -> resync_pulse once, err_count unchanged, locked=1. Macro undefined -> err_pulse once, err_count+1.
- Clear and reset collision:
  - clr_err asserted on the same cycle as a mismatch -> err_pulse=1 and err_count=0.
  - rst pulsed while locked=1 -> all outputs 0 the next cycle.
